// File: rtl/chance_looper_n.sv
// rtl/chance_looper_n.sv - stop-the-counter game: sums counter values captured on stop edges over ROUNDS rounds
module chance_looper_n #(
    parameter int CNT_W  = 4,
    parameter int ROUNDS = 3,
    parameter int SUM_W  = 7,
    parameter int SAT    = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            stop,
    output logic [SUM_W-1:0]                answer,
    output logic                            valid,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(ROUNDS+1)-1:0]     round_cnt
);

    localparam int RW = $clog2(ROUNDS + 1);
    localparam int AW = SUM_W + CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             stop_q;
    logic             stop_edge;
    logic [SUM_W-1:0] sum, sum_nxt, sum_add, answer_nxt;
    logic [RW-1:0]    round_nxt, round_inc;
    logic             valid_nxt;
    logic [AW-1:0]    add_full;

    assign stop_edge = stop & ~stop_q;
    assign round_inc = round_cnt + 1'b1;
    assign add_full  = AW'(sum) + AW'(cnt);

    // Extra headroom in add_full lets overflow be detected before clamping or truncating.
    always_comb begin
        sum_add = add_full[SUM_W-1:0];
        if ((SAT != 0) && (add_full > AW'({SUM_W{1'b1}}))) begin
            sum_add = '1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Start always wins over a coincident stop edge, so it is tested first in RUN.
    always_comb begin
        state_nxt  = state;
        sum_nxt    = sum;
        round_nxt  = round_cnt;
        answer_nxt = answer;
        valid_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    sum_nxt   = '0;
                    round_nxt = '0;
                end
            end
            RUN: begin
                if (start) begin
                    sum_nxt   = '0;
                    round_nxt = '0;
                end else if (stop_edge) begin
                    sum_nxt   = sum_add;
                    round_nxt = round_inc;
                    if (round_inc == RW'(ROUNDS)) begin
                        answer_nxt = sum_add;
                        valid_nxt  = 1'b1;
                        state_nxt  = DONE;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    sum_nxt   = '0;
                    round_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            stop_q    <= 1'b0;
            sum       <= '0;
            round_cnt <= '0;
            answer    <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cnt       <= stop ? cnt : cnt + 1'b1;
            stop_q    <= stop;
            sum       <= sum_nxt;
            round_cnt <= round_nxt;
            answer    <= answer_nxt;
            valid     <= valid_nxt;
            busy      <= (state_nxt == RUN);
            done      <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_chance_looper_n.sv
// tb/tb_chance_looper_n.sv - randomized and directed bench for chance_looper_n against a behavioural game model
module tb_chance_looper_n;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0;
    logic [6:0] ans_m;
    logic [4:0] ans_s, ans_w;
    logic       v_m, v_s, v_w, busy, done, b_s, b_w, d_s, d_w;
    logic [1:0] rc, rc_s, rc_w;

    chance_looper_n dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .answer(ans_m), .valid(v_m), .busy(busy), .done(done), .round_cnt(rc));
    chance_looper_n #(.SUM_W(5), .SAT(1)) dut_s (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .answer(ans_s), .valid(v_s), .busy(b_s), .done(d_s), .round_cnt(rc_s));
    chance_looper_n #(.SUM_W(5), .SAT(0)) dut_w (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .answer(ans_w), .valid(v_w), .busy(b_w), .done(d_w), .round_cnt(rc_w));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, n_valid = 0;
    int m_cnt, m_stopq, m_state, m_round, m_valid;
    int m_sum[3], m_ans[3];

    function automatic int addk(int k, int a, int c);
        int s = a + c;
        if (k == 0) return (s > 127) ? 127 : s;
        if (k == 1) return (s > 31) ? 31 : s;
        return s % 32;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_stopq = 0; m_state = 0; m_round = 0; m_valid = 0;
        for (int k = 0; k < 3; k++) begin m_sum[k] = 0; m_ans[k] = 0; end
    endtask

    task automatic compare();
        chk("answer", ans_m, m_ans[0]);
        chk("answer_sat5", ans_s, m_ans[1]);
        chk("answer_wrap5", ans_w, m_ans[2]);
        chk("valid", v_m, m_valid);
        chk("valid_sat5", v_s, m_valid);
        chk("valid_wrap5", v_w, m_valid);
        chk("busy", busy, m_state == 1);
        chk("done", done, m_state == 2);
        chk("round_cnt", rc, m_round);
        chk("cnt", dut.cnt, m_cnt);
        if (v_m === 1'b1) n_valid++;
    endtask

    task automatic step();
        int edge_hit;
        @(posedge clk);
        edge_hit = (stop && !m_stopq);
        m_valid = 0;
        case (m_state)
            0: if (start) begin m_state = 1; m_round = 0; for (int k = 0; k < 3; k++) m_sum[k] = 0; end
            1: if (start) begin
                   m_round = 0; for (int k = 0; k < 3; k++) m_sum[k] = 0;
               end else if (edge_hit) begin
                   for (int k = 0; k < 3; k++) m_sum[k] = addk(k, m_sum[k], m_cnt);
                   m_round++;
                   if (m_round == 3) begin
                       for (int k = 0; k < 3; k++) m_ans[k] = m_sum[k];
                       m_valid = 1; m_state = 2;
                   end
               end
            default: if (start) begin m_state = 1; m_round = 0; for (int k = 0; k < 3; k++) m_sum[k] = 0; end
        endcase
        if (!stop) m_cnt = (m_cnt + 1) % 16;
        m_stopq = stop;
        #1 compare();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        compare();
        @(posedge clk);
        #1 compare();
        #2 reset = 1'b0;
    endtask

    task automatic wait_cnt(int v);
        int g = 0;
        start = 1'b0; stop = 1'b0;
        while (m_cnt != v && g < 40) begin step(); g++; end
        chk("wait_cnt", dut.cnt, v);
    endtask

    task automatic pulse();
        stop = 1'b1; step();
        stop = 1'b0; step();
    endtask

    task automatic start_game();
        start = 1'b1; step();
        start = 1'b0;
    endtask

    int v0;

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #1 compare();
        chk("reset_answer", ans_m, 0);
        @(posedge clk);
        #1 compare();
        #2 reset = 1'b0;

        // basic game: edges at 5, 8, 14
        start_game();
        v0 = n_valid;
        wait_cnt(5); pulse();
        wait_cnt(8); pulse();
        wait_cnt(14); pulse();
        step(); step();
        chk("basic_answer", ans_m, 27);
        chk("basic_done", done, 1);
        chk("basic_round", rc, 3);
        chk("basic_valid_pulses", n_valid - v0, 1);

        // three edges at 15: wrap and saturation on 5-bit instances
        start_game();
        for (int i = 0; i < 3; i++) begin wait_cnt(15); pulse(); end
        chk("sat_answer", ans_s, 31);
        chk("wrap_answer", ans_w, 13);
        chk("wide_answer", ans_m, 45);

        // held stop counts once and freezes cnt
        start_game();
        wait_cnt(3);
        stop = 1'b1;
        repeat (10) step();
        chk("held_round", rc, 1);
        chk("held_cnt", dut.cnt, 3);
        stop = 1'b0; step();

        // reset after two edges
        wait_cnt(7); pulse();
        v0 = n_valid;
        do_reset();
        chk("rst_answer", ans_m, 0);
        chk("rst_round", rc, 0);
        chk("rst_busy", busy, 0);
        repeat (5) step();
        chk("rst_no_valid", n_valid - v0, 0);

        // start coinciding with a stop edge
        start_game();
        wait_cnt(2); pulse();
        start = 1'b1; stop = 1'b1; step();
        chk("coinc_round", rc, 0);
        chk("coinc_sum", dut.sum, 0);
        chk("coinc_busy", busy, 1);
        start = 1'b0; stop = 1'b0; step();
        wait_cnt(4); pulse();
        wait_cnt(9); pulse();
        wait_cnt(1); pulse();
        chk("coinc_answer", ans_m, 14);

        // stop edge in DONE is ignored
        v0 = n_valid;
        pulse();
        chk("done_answer", ans_m, 14);
        chk("done_round", rc, 3);
        chk("done_no_valid", n_valid - v0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                do_reset();
            end else begin
                start = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 3) == 0) stop = ~stop;
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
